// File: rtl/multi_channel_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_debouncer
// Brief    : Per-channel synchroniser, stability filter, edge and long-press
//            strobes for push-button / switch inputs.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int ACTIVE_LOW    = 0,
    parameter int LONG_CYCLES   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press
);

    localparam int                 c_cnt_w       = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    // Raw level seen when the button is released.
    localparam logic               c_idle        = (ACTIVE_LOW != 0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_cnt_w-1:0]     r_cnt;
        logic                   r_out;
        logic                   r_rise;
        logic                   r_fall;
        logic                   w_s;

        assign w_s     = r_sync[SYNC_STAGES-1] ^ c_idle;
        assign out[i]  = r_out;
        assign rise[i] = r_rise;
        assign fall[i] = r_fall;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync <= {SYNC_STAGES{c_idle}};
                r_cnt  <= '0;
                r_out  <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], in[i]};
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_s == r_out) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_stable_last) begin
                    // Disagreement held for the full window: accept the new level.
                    r_cnt  <= '0;
                    r_out  <= w_s;
                    r_rise <= w_s;
                    r_fall <= ~w_s;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end

        if (LONG_CYCLES > 0) begin : g_long
            localparam int                  c_hold_w    = $clog2(LONG_CYCLES + 1);
            localparam logic [c_hold_w-1:0] c_long_last = c_hold_w'(LONG_CYCLES - 1);
            localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

            logic [c_hold_w-1:0] r_hold;
            logic                r_fired;
            logic                r_long;

            assign long_press[i] = r_long;

            always_ff @(posedge clk) begin
                if (!rst_n || !r_out) begin
                    r_hold  <= '0;
                    r_fired <= 1'b0;
                    r_long  <= 1'b0;
                end else if (!r_fired) begin
                    r_hold  <= r_hold + c_hold_one;
                    r_long  <= (r_hold == c_long_last);
                    r_fired <= (r_hold == c_long_last);
                end else begin
                    // Fired once for this press; hold saturates until release.
                    r_long <= 1'b0;
                end
            end
        end else begin : g_no_long
            assign long_press[i] = 1'b0;
        end
    end

endmodule
`default_nettype wire
